rcu: RTL and testbench

//  USB receiver control unit. Sits directly downstream of the sampling timer and the edge/EOP detectors.

---
 rtl/usb_rx_pkg.sv | 25 ++
 rtl/rcu_if.sv | 26 ++
 rtl/rcu.sv | 119 +++++++++++
 tb/tb_rcu.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/usb_rx_pkg.sv
// Shared types and helpers for the USB receive path.
// Contents: rcu_state_t (receiver control FSM states), SYNC_DEFAULT (expected
// SYNC byte), pid_ok() (PID nibble/complement integrity test).
package usb_rx_pkg;

  localparam logic [7:0] SYNC_DEFAULT = 8'h80;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_SYNC_RX  = 4'd1,
    ST_SYNC_CHK = 4'd2,
    ST_DATA_RX  = 4'd3,
    ST_STORE    = 4'd4,
    ST_EOP_HOLD = 4'd5,
    ST_ERR_EOP  = 4'd6,
    ST_ERR_IDLE = 4'd7,
    ST_PID_CHK  = 4'd8
  } rcu_state_t;

  // A PID byte carries its 4-bit code in the low nibble and the complement above it.
  function automatic logic pid_ok(input logic [7:0] pid);
    return pid[7:4] == ~pid[3:0];
  endfunction

endpackage

// File: rtl/rcu_if.sv
// Receiver control bus between the timer / edge / EOP detectors and the rcu.
// master : detector/timer side, drives d_edge, eop, shift_enable, byte_received, rcv_data;
//          observes rcving, w_enable, r_error.
// slave  : rcu side, the mirror image.
interface rcu_if #(
  parameter int unsigned DATA_W = 8
);
  logic              d_edge;
  logic              eop;
  logic              shift_enable;
  logic              byte_received;
  logic [DATA_W-1:0] rcv_data;
  logic              rcving;
  logic              w_enable;
  logic              r_error;

  modport master (
    output d_edge, eop, shift_enable, byte_received, rcv_data,
    input  rcving, w_enable, r_error
  );

  modport slave (
    input  d_edge, eop, shift_enable, byte_received, rcv_data,
    output rcving, w_enable, r_error
  );
endinterface

// File: rtl/rcu.sv
// USB receiver control unit: tracks packet framing, checks the SYNC byte,
// pulses w_enable once per stored data byte and flags malformed packets.
// Ports:
//   clk    - system clock, rising edge
//   n_rst  - asynchronous active-low reset
//   bus    - rcu_if.slave: d_edge, eop, shift_enable, byte_received, rcv_data in;
//            rcving, w_enable, r_error out (all registered)
// Build option: define RCU_PID_CHECK_EN to verify the PID integrity of the first
// data byte after it has been written out.
module rcu
  import usb_rx_pkg::*;
#(
  parameter int unsigned       DATA_W    = 8,
  parameter logic [DATA_W-1:0] SYNC_BYTE = DATA_W'(SYNC_DEFAULT)
) (
  input  logic clk,
  input  logic n_rst,
  rcu_if.slave bus
);

  localparam int unsigned BIT_CNT_W = 3;

  rcu_state_t           state;
  rcu_state_t           state_nxt;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [BIT_CNT_W-1:0] bit_cnt_nxt;
  logic                 rcving_nxt;
  logic                 r_error_nxt;
  logic                 w_enable_nxt;
  logic                 eop_se;

`ifdef RCU_PID_CHECK_EN
  logic pid_pend;
  logic pid_pend_nxt;
`endif

  // EOP only counts at a bit sample point.
  assign eop_se = bus.eop & bus.shift_enable;

  // Next state, bit counter and output decode.
  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = '0;
    rcving_nxt   = 1'b0;
    r_error_nxt  = 1'b0;
    w_enable_nxt = 1'b0;
`ifdef RCU_PID_CHECK_EN
    pid_pend_nxt = pid_pend;
`endif

    unique case (state)
      ST_IDLE:     if (bus.d_edge) state_nxt = ST_SYNC_RX;
      ST_SYNC_RX: begin
        if (bus.byte_received) state_nxt = ST_SYNC_CHK;
        else if (eop_se)       state_nxt = ST_ERR_EOP;
      end
      ST_SYNC_CHK: state_nxt = (bus.rcv_data == SYNC_BYTE) ? ST_DATA_RX : ST_ERR_EOP;
      // A byte landing on the EOP sample wins; EOP is re-evaluated next sample.
      ST_DATA_RX: begin
        if (bus.byte_received) state_nxt = ST_STORE;
        else if (eop_se)       state_nxt = (bit_cnt == '0) ? ST_EOP_HOLD : ST_ERR_EOP;
      end
`ifdef RCU_PID_CHECK_EN
      ST_STORE:    state_nxt = pid_pend ? ST_PID_CHK : ST_DATA_RX;
      ST_PID_CHK:  state_nxt = pid_ok(8'(bus.rcv_data)) ? ST_DATA_RX : ST_ERR_EOP;
`else
      ST_STORE:    state_nxt = ST_DATA_RX;
`endif
      // The EOP->J edge closes the packet and must not start a new one.
      ST_EOP_HOLD: if (bus.d_edge) state_nxt = ST_IDLE;
      ST_ERR_EOP:  if (eop_se)     state_nxt = ST_ERR_IDLE;
      ST_ERR_IDLE: if (bus.d_edge) state_nxt = ST_SYNC_RX;
      default:     state_nxt = ST_IDLE;
    endcase

`ifdef RCU_PID_CHECK_EN
    // Armed by a good SYNC; consumed by the first data byte's STORE.
    if (state == ST_SYNC_CHK)   pid_pend_nxt = 1'b1;
    else if (state == ST_STORE) pid_pend_nxt = 1'b0;
`endif

    if (bus.byte_received)
      bit_cnt_nxt = '0;
    else if (state == ST_DATA_RX && bus.shift_enable)
      bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
    else if (state == ST_DATA_RX || state == ST_STORE)
      bit_cnt_nxt = bit_cnt;

    rcving_nxt  = state_nxt inside {ST_SYNC_RX, ST_SYNC_CHK, ST_DATA_RX, ST_STORE,
                                    ST_PID_CHK, ST_ERR_EOP};
    r_error_nxt = state_nxt inside {ST_ERR_EOP, ST_ERR_IDLE};
    // Write strobe trails STORE by one register stage (byte_received -> w_enable = 2).
    w_enable_nxt = (state == ST_STORE);
  end

  // State, bit counter and registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      bus.rcving   <= 1'b0;
      bus.r_error  <= 1'b0;
      bus.w_enable <= 1'b0;
`ifdef RCU_PID_CHECK_EN
      pid_pend     <= 1'b0;
`endif
    end else begin
      state        <= state_nxt;
      bit_cnt      <= bit_cnt_nxt;
      bus.rcving   <= rcving_nxt;
      bus.r_error  <= r_error_nxt;
      bus.w_enable <= w_enable_nxt;
`ifdef RCU_PID_CHECK_EN
      pid_pend     <= pid_pend_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_rcu.sv
// Self-checking bench for rcu: emulates the timer/detectors at packet level and
// predicts writes, error flag and rcving from the packet contents.
module tb_rcu;
  import usb_rx_pkg::*;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned BIT_CYC = 4;

  logic clk;
  logic n_rst;
  int   cyc;
  int   errors;
  int   checks;
  bit   prev_err;

  int   exp_we_q[$];
  int   obs_we_q[$];

  rcu_if #(.DATA_W(DATA_W)) bus ();

  rcu #(.DATA_W(DATA_W), .SYNC_BYTE(8'h80)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record the cycle of every write strobe.
  always @(negedge clk) if (bus.w_enable === 1'b1) obs_we_q.push_back(cyc);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.d_edge        = 1'b0;
    bus.shift_enable  = 1'b0;
    bus.byte_received = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One bit period; the last bit of a byte also raises byte_received.
  task automatic send_bit(input bit last, input logic [7:0] data, input bit wr, input bit noise);
    bus.shift_enable = 1'b1;
    if (last) begin
      bus.byte_received = 1'b1;
      bus.rcv_data      = data;
      if (wr) exp_we_q.push_back(cyc + 2);
    end
    tick();
    for (int i = 1; i < BIT_CYC; i++) begin
      if (noise && $urandom_range(0, 7) == 0) bus.d_edge = 1'b1;
      tick();
    end
  endtask

  task automatic send_byte(input logic [7:0] data, input bit wr, input bit noise, input bit eop_last);
    for (int k = 0; k < 8; k++) begin
      if (k == 7 && eop_last) bus.eop = 1'b1;
      send_bit(k == 7, data, wr, noise);
    end
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_n_writes"}, 32'(obs_we_q.size()), 32'(exp_we_q.size()));
    for (int i = 0; i < exp_we_q.size(); i++)
      check({tag, "_we_cycle"}, (i < obs_we_q.size()) ? 32'(obs_we_q[i]) : 32'hFFFF_FFFF,
            32'(exp_we_q[i]));
    exp_we_q.delete();
    obs_we_q.delete();
  endtask

  // Whole packet: start edge, SYNC, data bytes, optional partial byte, 2-bit EOP.
  task automatic send_packet(input string tag, input logic [7:0] sync, input int nbytes,
                             input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3,
                             input int partial, input bit eop_last, input bit noise);
    logic [7:0] data [4];
    int         n_wr;
    bit         err_early;
    bit         err;
    data[0] = b0; data[1] = b1; data[2] = b2; data[3] = b3;

    // Reference: what the packet should produce, from its contents alone.
    err_early = (sync != 8'h80);
    n_wr      = err_early ? 0 : nbytes;
`ifdef RCU_PID_CHECK_EN
    if (!err_early && nbytes > 0 && (data[0][7:4] ^ data[0][3:0]) != 4'hF) begin
      err_early = 1'b1;
      n_wr      = 1;
    end
`endif
    err = err_early || (partial != 0);

    check({tag, "_err_held"}, 32'(bus.r_error), 32'(prev_err));
    bus.d_edge = 1'b1;
    tick();
    check({tag, "_start_rcving"}, 32'(bus.rcving), 32'd1);
    check({tag, "_start_rerr"}, 32'(bus.r_error), 32'd0);
    idle($urandom_range(0, 3));

    send_byte(sync, 1'b0, noise, 1'b0);
    for (int i = 0; i < nbytes; i++)
      send_byte(data[i], i < n_wr, noise, eop_last && (i == nbytes - 1));
    for (int i = 0; i < partial; i++) send_bit(1'b0, 8'h00, 1'b0, noise);

    check({tag, "_pre_eop_rcving"}, 32'(bus.rcving), 32'd1);
    check({tag, "_pre_eop_rerr"}, 32'(bus.r_error), 32'(err_early));

    bus.eop = 1'b1;
    send_bit(1'b0, 8'h00, 1'b0, 1'b0);
    send_bit(1'b0, 8'h00, 1'b0, 1'b0);
    bus.eop = 1'b0;
    idle(2);
    check({tag, "_post_eop_rcving"}, 32'(bus.rcving), 32'd0);
    check({tag, "_post_eop_rerr"}, 32'(bus.r_error), 32'(err));

    if (!err) begin
      // EOP->J transition returns to idle without starting a packet.
      bus.d_edge = 1'b1;
      tick();
      idle(2);
      check({tag, "_exit_edge_rcving"}, 32'(bus.rcving), 32'd0);
    end
    compare_writes(tag);
    prev_err = err;
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    prev_err = 1'b0;
    n_rst    = 1'b0;
    bus.d_edge        = 1'b0;
    bus.eop           = 1'b0;
    bus.shift_enable  = 1'b0;
    bus.byte_received = 1'b0;
    bus.rcv_data      = '0;

    idle(3);
    check("reset_rcving", 32'(bus.rcving), 32'd0);
    check("reset_wen", 32'(bus.w_enable), 32'd0);
    check("reset_rerr", 32'(bus.r_error), 32'd0);
    n_rst = 1'b1;
    idle(2);

    send_packet("good", 8'h80, 3, 8'hC3, 8'hA5, 8'h5A, 8'h00, 0, 1'b0, 1'b0);
    send_packet("bad_sync", 8'h81, 2, 8'h11, 8'h22, 8'h00, 8'h00, 0, 1'b0, 1'b0);
    send_packet("after_err", 8'h80, 1, 8'hD2, 8'h00, 8'h00, 8'h00, 0, 1'b0, 1'b0);
    send_packet("partial", 8'h80, 1, 8'h4B, 8'h00, 8'h00, 8'h00, 4, 1'b0, 1'b0);
    send_packet("recover", 8'h80, 2, 8'h69, 8'hE1, 8'h00, 8'h00, 0, 1'b0, 1'b0);
    send_packet("eop_on_byte", 8'h80, 2, 8'hE1, 8'h77, 8'h00, 8'h00, 0, 1'b1, 1'b0);
    send_packet("pid_3c", 8'h80, 2, 8'h3C, 8'h10, 8'h00, 8'h00, 0, 1'b0, 1'b0);
    send_packet("pid_c3", 8'h80, 2, 8'hC3, 8'h20, 8'h00, 8'h00, 0, 1'b0, 1'b0);
    send_packet("pid_33", 8'h80, 3, 8'h33, 8'h44, 8'h55, 8'h00, 0, 1'b0, 1'b0);
    send_packet("empty", 8'h80, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1'b0, 1'b0);

    // Reset while a stored byte's write strobe is still in flight.
    bus.d_edge = 1'b1;
    tick();
    send_byte(8'h80, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) send_bit(1'b0, 8'h00, 1'b0, 1'b0);
    bus.shift_enable  = 1'b1;
    bus.byte_received = 1'b1;
    bus.rcv_data      = 8'hC3;
    tick();
    n_rst = 1'b0;
    #1;
    check("rst_mid_rcving", 32'(bus.rcving), 32'd0);
    check("rst_mid_wen", 32'(bus.w_enable), 32'd0);
    check("rst_mid_rerr", 32'(bus.r_error), 32'd0);
    idle(2);
    n_rst = 1'b1;
    idle(4);
    check("rst_after_rcving", 32'(bus.rcving), 32'd0);
    compare_writes("rst_mid");
    prev_err = 1'b0;

    for (int p = 0; p < 25; p++) begin
      logic [7:0] s;
      int         nb;
      int         part;
      bit         el;
      s    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h80;
      nb   = $urandom_range(0, 4);
      part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      el   = (s == 8'h80 && part == 0 && nb > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      send_packet("rand", s, nb, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                  part, el, 1'b1);
      idle($urandom_range(0, 5));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
